radix_mult_param: RTL and testbench

RADIX_MULT_PARAM -- requirements
Module: radix_mult_param

---
 rtl/radix_mult_param.sv | 121 ++++++++++++
 tb/tb_radix_mult_param.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix_mult_param.sv
// Multi-cycle radix-2^RADIX_LOG2 multiplier.
// Retires RADIX_LOG2 multiplier bits per cycle, LSB-first, into an OUTW-bit
// accumulator. Signed operands are turned into magnitudes when they are
// latched, and the product sign is applied on the final cycle.
module radix_mult_param #(
    parameter int unsigned FRACW      = 16,
    parameter int unsigned RADIX_LOG2 = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      isSigned,
    input  logic [FRACW:0]            mulIn1,
    input  logic [FRACW:0]            mulIn2,
    output logic [2*(FRACW+1)-1:0]    mulOut,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned WIDTH = FRACW + 1;
    localparam int unsigned OUTW  = 2 * WIDTH;
    localparam int unsigned NITER = (WIDTH + RADIX_LOG2 - 1) / RADIX_LOG2;
    // Multiplier register is padded to a whole number of digits; the pad is zero
    localparam int unsigned MPW   = NITER * RADIX_LOG2;
    localparam int unsigned CNTW  = $clog2(NITER + 1);
    localparam logic [CNTW-1:0] ITER_LAST = CNTW'(NITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [OUTW-1:0]       r_mcand;    // multiplicand, pre-shifted to current digit weight
    logic [MPW-1:0]        r_mplier;   // multiplier, shifted right one digit per cycle
    logic [OUTW-1:0]       r_acc;
    logic [CNTW-1:0]       r_iter;
    logic                  r_neg;
    logic [OUTW-1:0]       r_out;
    logic                  r_busy;
    logic                  r_done;

    logic [WIDTH-1:0]      w_mag1;
    logic [WIDTH-1:0]      w_mag2;
    logic [RADIX_LOG2-1:0] w_digit;
    logic [OUTW-1:0]       w_partial;
    logic [OUTW-1:0]       w_sum;
    logic                  w_last;

    // Operand magnitudes; the most negative value maps to 2^FRACW, which still fits in WIDTH bits
    always_comb begin
        w_mag1 = (isSigned && mulIn1[WIDTH-1]) ? (~mulIn1 + 1'b1) : mulIn1;
        w_mag2 = (isSigned && mulIn2[WIDTH-1]) ? (~mulIn2 + 1'b1) : mulIn2;
    end

    // Digit partial product d*multiplicand as a short shift-and-add, then accumulate
    always_comb begin
        w_digit   = r_mplier[RADIX_LOG2-1:0];
        w_partial = '0;
        for (int unsigned k = 0; k < RADIX_LOG2; k++) begin
            if (w_digit[k]) begin
                w_partial = w_partial + (r_mcand << k);
            end
        end
        w_sum  = r_acc + w_partial;
        w_last = (r_iter == ITER_LAST);
    end

    // Control FSM and datapath registers, all outputs registered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_iter   <= '0;
            r_neg    <= 1'b0;
            r_out    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_mcand  <= OUTW'(w_mag1);
                        r_mplier <= MPW'(w_mag2);
                        r_neg    <= isSigned & (mulIn1[WIDTH-1] ^ mulIn2[WIDTH-1]);
                        r_acc    <= '0;
                        r_iter   <= '0;
                        r_done   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << RADIX_LOG2;
                    r_mplier <= r_mplier >> RADIX_LOG2;
                    r_iter   <= r_iter + 1'b1;
                    if (w_last) begin
                        r_out   <= r_neg ? (~w_sum + 1'b1) : w_sum;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign mulOut = r_out;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_radix_mult_param.sv
// Directed and swept checks for radix_mult_param at all four radices.
// Index 4 (RADIX_LOG2=4, the default) carries the directed scenarios.
module tb_radix_mult_param;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [16:0] a_in;
    logic [16:0] b_in;
    logic [33:0] mo [1:4];
    logic        bz [1:4];
    logic        dn [1:4];

    int n_checks;
    int n_fail;

    radix_mult_param #(.FRACW(16), .RADIX_LOG2(1)) u_r1 (
        .clock(clk), .reset(rst), .start(start), .isSigned(sgn),
        .mulIn1(a_in), .mulIn2(b_in), .mulOut(mo[1]), .busy(bz[1]), .done(dn[1]));
    radix_mult_param #(.FRACW(16), .RADIX_LOG2(2)) u_r2 (
        .clock(clk), .reset(rst), .start(start), .isSigned(sgn),
        .mulIn1(a_in), .mulIn2(b_in), .mulOut(mo[2]), .busy(bz[2]), .done(dn[2]));
    radix_mult_param #(.FRACW(16), .RADIX_LOG2(3)) u_r3 (
        .clock(clk), .reset(rst), .start(start), .isSigned(sgn),
        .mulIn1(a_in), .mulIn2(b_in), .mulOut(mo[3]), .busy(bz[3]), .done(dn[3]));
    radix_mult_param #(.FRACW(16), .RADIX_LOG2(4)) u_r4 (
        .clock(clk), .reset(rst), .start(start), .isSigned(sgn),
        .mulIn1(a_in), .mulIn2(b_in), .mulOut(mo[4]), .busy(bz[4]), .done(dn[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start one operation and check the default instance for 5 busy cycles then the result
    task automatic run_op(input string name, input logic [16:0] a, input logic [16:0] b,
                          input logic s, input logic [33:0] exp_v);
        sgn = s; a_in = a; b_in = b; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (bz[4] !== 1'b1 || dn[4] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s run cyc %0d: busy=%b done=%b, required busy=1 done=0", name, c, bz[4], dn[4]);
            end
            tick;
        end
        n_checks++;
        if (dn[4] !== 1'b1 || bz[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s finish: busy=%b done=%b, required busy=0 done=1", name, bz[4], dn[4]);
        end
        n_checks++;
        if (mo[4] !== exp_v) begin
            n_fail++;
            $display("FAIL %s result: got %h, required %h", name, mo[4], exp_v);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; sgn = 1'b0; a_in = '0; b_in = '0;
        tick; tick;
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (mo[k] !== 34'h0 || bz[k] !== 1'b0 || dn[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: mulOut=%h busy=%b done=%b, required 0/0/0", k, mo[k], bz[k], dn[k]);
            end
        end
    endtask

    task automatic test_unsigned;
        run_op("umax", 17'h1FFFF, 17'h1FFFF, 1'b0, 34'h3FFFC0001);
        run_op("u3x5", 17'd3, 17'd5, 1'b0, 34'd15);
        run_op("uzero", 17'd0, 17'h1FFFF, 1'b0, 34'd0);
    endtask

    task automatic test_signed;
        run_op("s_m1m1", 17'h1FFFF, 17'h1FFFF, 1'b1, 34'h000000001);
        run_op("s_minmin", 17'h10000, 17'h10000, 1'b1, 34'h100000000);
        run_op("s_minx1", 17'h10000, 17'h00001, 1'b1, 34'h3FFFF0000);
        run_op("s_m3x5", 17'h1FFFD, 17'd5, 1'b1, 34'h3FFFFFFF1);
        run_op("s_zero", 17'd0, 17'h10000, 1'b1, 34'd0);
    endtask

    task automatic test_hold;
        run_op("hold_op", 17'd1234, 17'd77, 1'b0, 34'd95018);
        for (int c = 0; c < 3; c++) begin
            tick;
            n_checks++;
            if (mo[4] !== 34'd95018 || dn[4] !== 1'b1 || bz[4] !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cyc %0d: mulOut=%h done=%b busy=%b, required %h/1/0", c, mo[4], dn[4], bz[4], 34'd95018);
            end
        end
    endtask

    task automatic test_ignored_start;
        sgn = 1'b0; a_in = 17'd3; b_in = 17'd5; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        sgn = 1'b1; a_in = 17'd7; b_in = 17'd7; start = 1'b1;
        tick;
        start = 1'b0; a_in = 17'h1ABCD; b_in = 17'h0F0F0;
        tick;
        n_checks++;
        if (dn[4] !== 1'b0 || bz[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_pre: done=%b busy=%b, required 0/1", dn[4], bz[4]);
        end
        tick;
        n_checks++;
        if (dn[4] !== 1'b1 || mo[4] !== 34'd15) begin
            n_fail++;
            $display("FAIL ign_result: done=%b mulOut=%h, required 1/%h", dn[4], mo[4], 34'd15);
        end
        for (int c = 0; c < 6; c++) begin
            tick;
            n_checks++;
            if (bz[4] !== 1'b0 || dn[4] !== 1'b1 || mo[4] !== 34'd15) begin
                n_fail++;
                $display("FAIL ign_no_second cyc %0d: busy=%b done=%b mulOut=%h, required 0/1/%h", c, bz[4], dn[4], mo[4], 34'd15);
            end
        end
    endtask

    task automatic test_reset_mid;
        sgn = 1'b0; a_in = 17'd100; b_in = 17'd200; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (mo[4] !== 34'd0 || dn[4] !== 1'b0 || bz[4] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: mulOut=%h done=%b busy=%b, required 0/0/0", c, mo[4], dn[4], bz[4]);
            end
            tick;
        end
        run_op("after_reset", 17'd100, 17'd200, 1'b0, 34'd20000);
    endtask

    task automatic test_reset_start;
        rst = 1'b1; start = 1'b1; sgn = 1'b0; a_in = 17'd5; b_in = 17'd5;
        tick;
        rst = 1'b0; start = 1'b0;
        n_checks++;
        if (mo[4] !== 34'd0 || dn[4] !== 1'b0 || bz[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_start: mulOut=%h done=%b busy=%b, required 0/0/0", mo[4], dn[4], bz[4]);
        end
        tick;
        n_checks++;
        if (bz[4] !== 1'b0 || dn[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_start_dropped: busy=%b done=%b, required 0/0", bz[4], dn[4]);
        end
    endtask

    // run_op returns right after done is seen, so chaining them starts from DONE with no idle cycle
    task automatic test_back_to_back;
        run_op("b2b_first", 17'd300, 17'd400, 1'b0, 34'd120000);
        run_op("b2b_second", 17'h1FFFE, 17'd3, 1'b1, 34'h3FFFFFFFA);
        run_op("b2b_third", 17'd65535, 17'd2, 1'b0, 34'd131070);
    endtask

    task automatic test_sweep;
        int          exp_lat [1:4];
        int          lat [1:4];
        logic        both;
        logic [16:0] a;
        logic [16:0] b;
        longint      sa;
        longint      sb;
        logic [33:0] exp_v;
        exp_lat[1] = 17; exp_lat[2] = 9; exp_lat[3] = 6; exp_lat[4] = 5;
        rst = 1'b1; start = 1'b0;
        tick;
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 100; i++) begin
                a = 17'($urandom);
                b = 17'($urandom);
                if (i == 0) begin a = 17'h10000; b = 17'h10000; end
                if (i == 1) begin a = 17'h1FFFF; b = 17'h10000; end
                if (m == 1) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                end else begin
                    sa = longint'(a);
                    sb = longint'(b);
                end
                exp_v = 34'(sa * sb);
                sgn = (m == 1); a_in = a; b_in = b; start = 1'b1;
                tick;
                start = 1'b0;
                both = 1'b0;
                for (int k = 1; k <= 4; k++) lat[k] = 0;
                for (int c = 1; c <= 20; c++) begin
                    tick;
                    for (int k = 1; k <= 4; k++) begin
                        if (dn[k] === 1'b1 && bz[k] === 1'b1) both = 1'b1;
                        if (dn[k] === 1'b1 && lat[k] == 0) lat[k] = c;
                    end
                end
                n_checks++;
                if (both !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sweep busy_done_overlap m=%0d i=%0d: overlap=%b, required 0", m, i, both);
                end
                for (int k = 1; k <= 4; k++) begin
                    n_checks++;
                    if (lat[k] != exp_lat[k]) begin
                        n_fail++;
                        $display("FAIL sweep latency r%0d m=%0d i=%0d: got %0d, required %0d", k, m, i, lat[k], exp_lat[k]);
                    end
                    n_checks++;
                    if (mo[k] !== exp_v) begin
                        n_fail++;
                        $display("FAIL sweep result r%0d m=%0d a=%h b=%h: got %h, required %h", k, m, a, b, mo[k], exp_v);
                    end
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0; start = 1'b0; sgn = 1'b0; a_in = '0; b_in = '0;
        test_reset;
        test_unsigned;
        test_signed;
        test_hold;
        test_ignored_start;
        test_reset_mid;
        test_reset_start;
        test_back_to_back;
        test_sweep;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
